// File: rtl/reg_file_pkg.sv
// Shared core definitions for the architectural register file: widths,
// the hardwired-zero index and the register index type.
package reg_file_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // True when an enabled access targets a real (non-x0) register equal to idx.
  function automatic logic idx_hit(input logic en, input reg_idx_t a, input reg_idx_t idx);
    return en && (a == idx) && (idx != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Decode/writeback side of the register file: two read ports with busy
// lookups, one writeback port, the allocation strobe and flush.
interface reg_file_if;
  import reg_file_pkg::*;

  // No valid/ready here: every request is a single-cycle strobe. Reads are
  // combinational and always answered; W_en and alloc_en are consumed on the
  // rising edge they are high; flush clears every busy bit on that edge.
  reg_idx_t w_R_1_num;
  reg_idx_t w_R_2_num;
  xlen_t    w_R_1;
  xlen_t    w_R_2;
  logic     R_1_busy;
  logic     R_2_busy;
  logic     W_en;
  reg_idx_t W_num;
  xlen_t    W_data;
  logic     alloc_en;
  reg_idx_t alloc_num;
  logic     flush;

  modport master (
    output w_R_1_num, w_R_2_num, W_en, W_num, W_data, alloc_en, alloc_num, flush,
    input  w_R_1, w_R_2, R_1_busy, R_2_busy
  );

  modport slave (
    input  w_R_1_num, w_R_2_num, W_en, W_num, W_data, alloc_en, alloc_num, flush,
    output w_R_1, w_R_2, R_1_busy, R_2_busy
  );

endinterface

// File: rtl/reg_scoreboard.sv
// In-flight write scoreboard: one busy bit per writable register, set by
// allocation, cleared by writeback or flush, with two combinational lookups.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int BYPASS = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     alloc_en,
  input  reg_idx_t alloc_num,
  input  logic     w_en,
  input  reg_idx_t w_num,
  input  logic     flush,
  input  reg_idx_t rd1_num,
  input  reg_idx_t rd2_num,
  output logic     rd1_busy,
  output logic     rd2_busy
);

  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:1] busy_d;
  logic [NREGS-1:0] busy_view;
  logic             rd1_retire;
  logic             rd2_retire;

  // Flush beats alloc, and a fresh alloc beats a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    for (int n = 1; n < NREGS; n++) begin
      if (flush) begin
        busy_d[n] = 1'b0;
      end else if (alloc_en && (alloc_num == reg_idx_t'(n))) begin
        busy_d[n] = 1'b1;
      end else if (w_en && (w_num == reg_idx_t'(n))) begin
        busy_d[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // x0 occupies bit 0 of the lookup vector and is never busy.
  assign busy_view = {busy_q, 1'b0};

  // A write retiring this cycle already counts as not-busy when forwarding.
  always_comb begin
    rd1_retire = 1'b0;
    rd2_retire = 1'b0;
    if (BYPASS != 0) begin
      rd1_retire = idx_hit(w_en, w_num, rd1_num);
      rd2_retire = idx_hit(w_en, w_num, rd2_num);
    end
  end

  assign rd1_busy = busy_view[rd1_num] & ~rd1_retire;
  assign rd2_busy = busy_view[rd2_num] & ~rd2_retire;

endmodule

// File: rtl/reg_file.sv
// Architectural register file: 31 writable XLEN-bit registers plus hardwired
// x0, two combinational read ports with optional write forwarding.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int BYPASS = 1
) (
  input  logic       clk,
  input  logic       reset,
  reg_file_if.slave  bus
);

  xlen_t regs     [NREGS-1:1];
  xlen_t reg_view [NREGS];
  logic  fwd_1;
  logic  fwd_2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // A write to x0 matches no entry and is dropped.
      for (int i = 1; i < NREGS; i++) begin
        if (bus.W_en && (bus.W_num == reg_idx_t'(i))) begin
          regs[i] <= bus.W_data;
        end
      end
    end
  end

  always_comb begin
    reg_view[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      reg_view[i] = regs[i];
    end
  end

  // Forwarding is deliberately not gated by reset; writeback keeps W_en low then.
  always_comb begin
    fwd_1 = 1'b0;
    fwd_2 = 1'b0;
    if (BYPASS != 0) begin
      fwd_1 = idx_hit(bus.W_en, bus.W_num, bus.w_R_1_num);
      fwd_2 = idx_hit(bus.W_en, bus.W_num, bus.w_R_2_num);
    end
  end

  assign bus.w_R_1 = fwd_1 ? bus.W_data : reg_view[bus.w_R_1_num];
  assign bus.w_R_2 = fwd_2 ? bus.W_data : reg_view[bus.w_R_2_num];

  reg_scoreboard #(
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .alloc_en  (bus.alloc_en),
    .alloc_num (bus.alloc_num),
    .w_en      (bus.W_en),
    .w_num     (bus.W_num),
    .flush     (bus.flush),
    .rd1_num   (bus.w_R_1_num),
    .rd2_num   (bus.w_R_2_num),
    .rd1_busy  (bus.R_1_busy),
    .rd2_busy  (bus.R_2_busy)
  );

endmodule
